// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
//   Shared definitions for the serial carry-skip adder scheduler:
//   default operand and slice widths, the scheduler state type and a helper
//   that sizes the per-operation skip counter.
// -----------------------------------------------------------------------------
package csa_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SLICE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter must hold every value from 0 to nslice inclusive.
  function automatic int unsigned skip_cnt_w(input int unsigned nslice);
    return (nslice < 1) ? 1 : $clog2(nslice + 1);
  endfunction

endpackage

// File: rtl/slice_add8.sv
// -----------------------------------------------------------------------------
// slice_add8
//   One W-bit carry-skip adder slice (W defaults to 8).
//   Ports:
//     a, b  in  W  slice operands
//     cin   in  1  carry into the slice
//     sum   out W  a + b + cin (low W bits)
//     cout  out 1  carry out of the slice
//     prop  out 1  every bit of the slice propagates (&(a ^ b))
// -----------------------------------------------------------------------------
module slice_add8 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         prop
);

  logic [W:0] ripple;

  always_comb begin
    ripple = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum    = ripple[W-1:0];
    prop   = &(a ^ b);
    // A fully propagating slice passes its carry-in straight through; the
    // ripple carry would produce the same value, the skip path is just shorter.
    cout   = prop ? cin : ripple[W];
  end

endmodule

// File: rtl/csa_slice_scheduler.sv
// -----------------------------------------------------------------------------
// csa_slice_scheduler
//   Shares one SLICE_W-bit carry-skip adder slice between two requesters.
//   A granted WIDTH-bit add is computed serially, least-significant slice
//   first, one slice per cycle, with the carry held in a register. Requesters
//   are arbitrated round-robin; a response carries the sum, the final carry,
//   the requester id and the number of fully propagating slices.
//
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     reqN_valid / reqN_ready     request handshake for requester N (0, 1)
//     reqN_a, reqN_b, reqN_cin    operands and carry-in for requester N
//     rsp_valid / rsp_ready       response handshake
//     rsp_sum, rsp_cout           (a + b + cin) mod 2^WIDTH, carry out
//     rsp_id                      requester that issued the operation
//     rsp_skips                   slices whose a ^ b was all ones
// -----------------------------------------------------------------------------
module csa_slice_scheduler
  import csa_pkg::*;
#(
  parameter  int unsigned WIDTH   = WIDTH_DEF,
  parameter  int unsigned SLICE_W = SLICE_W_DEF,
  localparam int unsigned NSLICE  = WIDTH / SLICE_W,
  localparam int unsigned SKIP_W  = skip_cnt_w(NSLICE)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req0_cin,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic              req1_cin,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_id,
  output logic [SKIP_W-1:0] rsp_skips
);

  localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [KW-1:0]      k_q, k_d;
  logic [SKIP_W-1:0]  skips_q, skips_d;
  logic               id_q, id_d;

  logic               grant0, grant1;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;
  logic               sl_prop;

  // Operand registers shift right one slice per RUN cycle, so the active
  // slice is always the low SLICE_W bits; no variable part-select needed.
  slice_add8 #(
    .W (SLICE_W)
  ) u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .prop (sl_prop)
  );

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not served last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid ||  last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    k_d        = k_q;
    skips_d    = skips_q;
    id_d       = id_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          carry_d = grant1 ? req1_cin : req0_cin;
          id_d    = grant1;
          sum_d   = '0;
          k_d     = '0;
          skips_d = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        // Each new slice result enters at the top; after NSLICE steps the
        // first slice computed has reached the least-significant position.
        sum_d   = (sum_q >> SLICE_W) | (WIDTH'(sl_sum) << (WIDTH - SLICE_W));
        carry_d = sl_cout;
        if (sl_prop) begin
          skips_d = skips_q + 1'b1;
        end
        if (k_q == KW'(NSLICE - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == ST_DONE);
    rsp_sum   = sum_q;
    rsp_cout  = carry_q;
    rsp_id    = id_q;
    rsp_skips = skips_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      skips_q <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      skips_q <= skips_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_csa_slice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_csa_slice_scheduler
//   Self-checking bench for csa_slice_scheduler at default parameters
//   (WIDTH 32, SLICE_W 8). Directed scenarios followed by a randomized run
//   against an arithmetic reference model with round-robin bookkeeping.
// -----------------------------------------------------------------------------
module tb_csa_slice_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [31:0] rsp_sum;
  logic [2:0]  rsp_skips;

  int checks = 0;
  int errors = 0;

  csa_slice_scheduler #(
    .WIDTH   (32),
    .SLICE_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .rsp_skips  (rsp_skips)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit addition and a byte-wise count of all-ones a^b.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic int ref_skips(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    int n;
    p = a ^ b;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (((p >> (8 * i)) & 32'hFF) == 32'hFF) n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic id);
    logic [32:0] r;
    r = ref_add(a, b, cin);
    check({tag, "_sum"},   64'(rsp_sum),   64'(r[31:0]));
    check({tag, "_cout"},  64'(rsp_cout),  64'(r[32]));
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_skips"}, 64'(rsp_skips), 64'(ref_skips(a, b)));
  endtask

  // Called at a negedge; steps whole cycles until rsp_valid or the budget ends.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  // Called just after a posedge in an IDLE cycle; presents one op alone.
  task automatic issue_wait(input int port, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, output int lat);
    if (port == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end
    @(negedge clk);
    check("issue_ready0", 64'(req0_ready), 64'(port == 0));
    check("issue_ready1", 64'(req1_ready), 64'(port == 1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    wait_rsp(1, lat);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready0"}, 64'(req0_ready), 64'd0);
    check({tag, "_ready1"}, 64'(req1_ready), 64'd0);
    check({tag, "_valid"},  64'(rsp_valid),  64'd0);
    check({tag, "_sum"},    64'(rsp_sum),    64'd0);
    check({tag, "_cout"},   64'(rsp_cout),   64'd0);
    check({tag, "_id"},     64'(rsp_id),     64'd0);
    check({tag, "_skips"},  64'(rsp_skips),  64'd0);
  endtask

  initial begin : main
    int lat, n, cyc;
    int rec_cyc[4];
    logic [31:0] o0a, o0b, o1a, o1b;
    logic        o0c, o1c;
    // random-phase model state
    logic [31:0] pa[2], pb[2];
    logic        pc[2];
    logic [1:0]  pv;
    logic        m_last, busy, eg0, eg1;
    logic [31:0] fa, fb;
    logic        fc, fid;
    int          issued, done;

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester 0, latency from the handshake cycle
    issue_wait(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_sum",   64'(rsp_sum),   64'h100);
    check("t1_cout",  64'(rsp_cout),  64'd0);
    check("t1_id",    64'(rsp_id),    64'd0);
    check("t1_skips", 64'(rsp_skips), 64'd0);
    @(posedge clk); #1;

    // Requester 1: full propagate chain, then top-bit carry out
    issue_wait(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
    check("t2a_sum",   64'(rsp_sum),   64'h0);
    check("t2a_cout",  64'(rsp_cout),  64'd1);
    check("t2a_id",    64'(rsp_id),    64'd1);
    check("t2a_skips", 64'(rsp_skips), 64'd4);
    @(posedge clk); #1;
    issue_wait(1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    check("t2b_sum",   64'(rsp_sum),   64'h0);
    check("t2b_cout",  64'(rsp_cout),  64'd1);
    check("t2b_id",    64'(rsp_id),    64'd1);
    check("t2b_skips", 64'(rsp_skips), 64'd0);
    @(posedge clk); #1;

    // Both valid continuously from reset: grants alternate, 6-cycle spacing
    o0a = 32'h0000_1234; o0b = 32'h0000_0F0F; o0c = 1'b1;
    o1a = 32'hFF00_FF00; o1b = 32'h00FF_00FF; o1c = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_a = o0a; req0_b = o0b; req0_cin = o0c; req0_valid = 1'b1;
    req1_a = o1a; req1_b = o1b; req1_cin = o1c; req1_valid = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      if (rsp_valid) begin
        rec_cyc[n] = cyc;
        if (n % 2 == 0) check_rsp("alt0", o0a, o0b, o0c, 1'b0);
        else            check_rsp("alt1", o1a, o1b, o1c, 1'b1);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt_count", 64'(n), 64'd4);
    check("alt_first", 64'(rec_cyc[0]), 64'd5);
    for (int i = 1; i < 4; i++) begin
      check("alt_spacing", 64'(rec_cyc[i] - rec_cyc[i-1]), 64'd6);
    end

    // Back-pressure in DONE while requester 1 waits
    rsp_ready = 1'b0;
    req0_a = o0a; req0_b = o0b; req0_cin = o0c; req0_valid = 1'b1;
    req1_a = o1a; req1_b = o1b; req1_cin = o1c; req1_valid = 1'b1;
    @(negedge clk);
    check("bp_grant0", 64'(req0_ready), 64'd1);
    check("bp_grant1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    wait_rsp(1, lat);
    check_rsp("bp_first", o0a, o0b, o0c, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check_rsp("bp_hold", o0a, o0b, o0c, 1'b0);
      check("bp_hold_ready0", 64'(req0_ready), 64'd0);
      check("bp_hold_ready1", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_valid",  64'(rsp_valid),  64'd1);
    check("bp_accept_ready1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_ready1", 64'(req1_ready), 64'd1);
    check("bp_next_ready0", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    wait_rsp(1, lat);
    check("bp_second_lat", 64'(lat), 64'd5);
    check_rsp("bp_second", o1a, o1b, o1c, 1'b1);
    @(posedge clk); #1;

    // Reset during RUN slice 2 abandons the op
    req0_a = 32'hDEAD_BEEF; req0_b = 32'h0123_4567; req0_cin = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    check("abort_grant", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("abort");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue_wait(0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    check("post_abort_lat", 64'(lat), 64'd5);
    check("post_abort_sum", 64'(rsp_sum), 64'h2345_6789);
    check("post_abort_id",  64'(rsp_id),  64'd0);
    @(posedge clk); #1;

    // Randomized traffic on both ports with gaps and back-pressure
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1'b1; busy = 1'b0; pv = 2'b00;
    issued = 0; done = 0;
    fa = '0; fb = '0; fc = 1'b0; fid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pa[p] = '0; pb[p] = '0; pc[p] = 1'b0;
    end
    for (int c = 0; c < 40000 && done < 1000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && (issued + int'(pv[0]) + int'(pv[1])) < 1000 &&
            $urandom_range(1, 0) == 1) begin
          pa[p] = $urandom;
          case ($urandom_range(3, 0))
            0:       pb[p] = ~pa[p];
            1:       pb[p] = ~pa[p] ^ (32'hFF << (8 * $urandom_range(3, 0)));
            default: pb[p] = $urandom;
          endcase
          pc[p] = 1'($urandom_range(1, 0));
          pv[p] = 1'b1;
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_cin = pc[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_cin = pc[1];
      rsp_ready  = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      eg0 = !busy && pv[0] && (!pv[1] ||  m_last);
      eg1 = !busy && pv[1] && (!pv[0] || !m_last);
      check("rnd_ready0", 64'(req0_ready), 64'(eg0));
      check("rnd_ready1", 64'(req1_ready), 64'(eg1));
      if (!busy) begin
        check("rnd_idle_rsp", 64'(rsp_valid), 64'd0);
      end else if (rsp_valid) begin
        check_rsp("rnd", fa, fb, fc, fid);
        if (rsp_ready) begin
          m_last = fid;
          busy   = 1'b0;
          done++;
        end
      end
      if (eg0) begin
        fa = pa[0]; fb = pb[0]; fc = pc[0]; fid = 1'b0;
        pv[0] = 1'b0; busy = 1'b1; issued++;
      end else if (eg1) begin
        fa = pa[1]; fb = pb[1]; fc = pc[1]; fid = 1'b1;
        pv[1] = 1'b0; busy = 1'b1; issued++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rnd_issued", 64'(issued), 64'd1000);
    check("rnd_done",   64'(done),   64'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_slice_scheduler.md
# csa_slice_scheduler

Two-port, round-robin-arbitrated sequencer that shares a single SLICE_W-bit carry-skip adder slice between two requesters. Each WIDTH-bit add is computed serially, one slice per cycle, least-significant first, with the carry held in a register. The block sits between operand producers and the 8-bit adder slice. It trades throughput for area and reports per-operation carry-skip statistics.

## Interface
- WIDTH, 32, operand/sum width; must be an integer multiple of SLICE_W
- SLICE_W, 8, width of the shared adder slice
- NSLICE, WIDTH/SLICE_W, derived, not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  A+B+Cin modulo 2^WIDTH
- rsp_cout  out  1  carry out of bit WIDTH-1
- rsp_id  out  1  requester that issued the operation
- rsp_skips  out  clog2(NSLICE+1)  number of slices whose propagate word (a^b) was all ones

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If no valid is high, stay in IDLE.
  - Otherwise grant one requester. With a single valid, grant that requester. With both valid, grant the requester that was not granted last.
  - reqN_ready for the granted port is asserted combinationally in this cycle. On valid&ready, latch a, b and cin, set carry register = cin, slice index k = 0, skip count = 0, record id, and go to RUN.
- RUN, one slice per cycle:
  - Compute a[k], b[k] and carry through the slice.
  - Write sum[k]; carry ← slice cout.
  - If &(a[k]^b[k]), increment the skip count.
  - k increments. After k = NSLICE-1, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_* hold stable.
  - On rsp_ready, go to IDLE and update the last-grant pointer to rsp_id.
- Both reqN_ready are 0 outside IDLE. Requesters hold valid and operands stable until ready.
- Skip behaviour: when a slice propagates fully, its carry-out equals its carry-in. The sum is unaffected; the counter is statistics only.
- Arithmetic: sum and cout equal the WIDTH+1-bit result of a+b+cin. No overflow flag.

## Timing
- Reset (rst_n low at a clock edge):
  - State = IDLE; last-grant pointer = 1, so req0 wins the first tie.
  - All outputs are 0: reqN_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_skips.
- Reset mid-RUN or mid-DONE aborts the operation. No response is produced and the in-flight operation is lost.
- Latency: handshake in cycle 0, RUN in cycles 1..NSLICE, rsp_valid first high in cycle NSLICE+1 (cycle 5 at defaults).
- Minimum initiation interval: NSLICE+2 cycles when rsp_ready is held high. This is IDLE + NSLICE RUN + DONE.
- Back-pressure: rsp_valid stays high and rsp_* stay constant while rsp_ready is low. No new grant occurs during this time.
- A request arriving during RUN or DONE waits; it is considered in the first IDLE cycle.
- A requester dropping valid in IDLE before ready is legal and produces no grant.

## Structure
- Package csa_pkg holds:
  - SLICE_W and WIDTH defaults;
  - the state enum {IDLE, RUN, DONE};
  - a helper function for the skip-counter width.
- Sub-module slice_add8: SLICE_W-bit adder slice (a, b, cin → sum, cout, prop = &(a^b)), instantiated once.
- The scheduler holds the FSM, arbiter pointer, operand registers, slice index, carry register, sum accumulator and skip counter.

## Test plan
- req0 a=0x000000FF b=0x00000001 cin=0 → rsp_sum=0x00000100, cout=0, id=0, skips=0; rsp_valid first high exactly 5 cycles after the handshake cycle.
- req1 a=0xFFFFFFFF b=0x00000000 cin=1 → rsp_sum=0x00000000, cout=1, id=1, skips=4. Then a=0x80000000 b=0x80000000 cin=0 → sum=0, cout=1, skips=0.
- Both valid continuously from reset with rsp_ready=1 → grants alternate 0,1,0,1. Responses are spaced 6 cycles apart and rsp_id matches each requester's operands.
- rsp_ready low for 3 cycles in DONE → rsp_* constant, both reqN_ready stay 0, no second grant; the next grant happens in the cycle after the accept.
- rst_n low for one cycle during RUN slice 2 → rsp_valid never rises for that op, all outputs 0. The next req0 0x12345678+0x11111111 returns 0x23456789.
- Random 1000 ops on both ports with random valid/rsp_ready gaps → every result matches the reference a+b+cin. Skips equals the count of slices with all-ones a^b, and no op is lost or duplicated.
